// File: rtl/cell_pos_reader.sv
// Read-side controller for a per-cell position memory: reads the particle
// count from word 0, then streams words 1..N downstream through a small
// credit-controlled output FIFO.
module cell_pos_reader #(
   parameter int unsigned DATA_WIDTH   = 96,
   parameter int unsigned ADDR_WIDTH   = 8,
   parameter int unsigned PARTICLE_NUM = 220,
   parameter int unsigned FIFO_DEPTH   = 4
) (
   input  logic                  clock,
   input  logic                  rst,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_WIDTH-1:0] particle_count,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic                  mem_rden,
   input  logic [DATA_WIDTH-1:0] mem_q,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [ADDR_WIDTH-1:0] out_index,
   output logic                  out_last
);

   localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [ADDR_WIDTH-1:0] MAX_CNT = ADDR_WIDTH'(PARTICLE_NUM - 1);

   typedef struct packed {
      logic [DATA_WIDTH-1:0] data;
      logic [ADDR_WIDTH-1:0] index;
      logic                  last;
   } entry_t;

   typedef enum logic [2:0] {IDLE, RD_CNT, WAIT_CNT, STREAM, DRAIN, FIN} state_t;

   state_t                state, state_nxt;
   logic                  wait_cnt;
   logic [ADDR_WIDTH-1:0] next_addr;
   logic [1:0]            sv;
   logic [ADDR_WIDTH-1:0] stag0, stag1;
   entry_t                store [FIFO_DEPTH];
   logic [PW-1:0]         wr_ptr, rd_ptr;
   logic [CW-1:0]         store_cnt;

   logic                  pop, push, head_free, store_we, store_re, rd_data;
   logic                  issue_nxt, credit_ok;
   logic [CW-1:0]         total, total_nxt;
   logic [1:0]            inflight_nxt;
   logic [ADDR_WIDTH-1:0] cnt_raw, cnt_clamped;
   entry_t                push_entry;

   function automatic logic [PW-1:0] inc_ptr(input logic [PW-1:0] p);
      return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // Occupancy, credit and FIFO steering; credit is evaluated on next-cycle values
   // so the registered read strobe obeys the rule in the cycle it is asserted.
   always_comb begin
      pop          = out_valid & out_ready;
      push         = sv[1];
      push_entry   = '{data: mem_q, index: stag1, last: (stag1 == particle_count)};
      head_free    = ~out_valid | pop;
      store_re     = head_free & (store_cnt != '0);
      store_we     = push & ~(head_free & (store_cnt == '0));
      rd_data      = mem_rden & (state == STREAM);
      total        = store_cnt + CW'(out_valid);
      total_nxt    = total + CW'(push) - CW'(pop);
      inflight_nxt = 2'(rd_data) + 2'(sv[0]);
      credit_ok    = ((CW+1)'(total_nxt) + (CW+1)'(inflight_nxt)) < (CW+1)'(FIFO_DEPTH);
      cnt_raw      = mem_q[ADDR_WIDTH-1:0];
      cnt_clamped  = (cnt_raw > MAX_CNT) ? MAX_CNT : cnt_raw;
   end

   // State register.
   always_ff @(posedge clock or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state and read-issue decision.
   always_comb begin
      state_nxt = state;
      issue_nxt = 1'b0;
      case (state)
         IDLE:     if (start) state_nxt = RD_CNT;
         RD_CNT:   state_nxt = WAIT_CNT;
         WAIT_CNT: if (wait_cnt) state_nxt = (cnt_clamped == '0) ? FIN : STREAM;
         STREAM:   if (rd_data && (mem_address == particle_count)) state_nxt = DRAIN;
         DRAIN:    if (pop && out_last && (store_cnt == '0) && (sv == 2'b00)) state_nxt = FIN;
         FIN:      state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
      issue_nxt = (state_nxt == STREAM) && credit_ok;
   end

   // Control outputs, read address generation and the 2-stage in-flight tracker.
   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         busy           <= 1'b0;
         done           <= 1'b0;
         mem_rden       <= 1'b0;
         mem_address    <= '0;
         next_addr      <= '0;
         wait_cnt       <= 1'b0;
         particle_count <= '0;
         sv             <= 2'b00;
         stag0          <= '0;
         stag1          <= '0;
      end else begin
         busy     <= (state_nxt == RD_CNT) || (state_nxt == WAIT_CNT) ||
                     (state_nxt == STREAM) || (state_nxt == DRAIN);
         done     <= (state_nxt == FIN);
         wait_cnt <= (state == WAIT_CNT) ? ~wait_cnt : 1'b0;
         if ((state == IDLE) && start) begin
            mem_rden    <= 1'b1;
            mem_address <= '0;
            next_addr   <= ADDR_WIDTH'(1);
         end else if (issue_nxt) begin
            mem_rden    <= 1'b1;
            mem_address <= next_addr;
            next_addr   <= next_addr + ADDR_WIDTH'(1);
         end else begin
            mem_rden    <= 1'b0;
         end
         if ((state == WAIT_CNT) && wait_cnt) particle_count <= cnt_clamped;
         sv    <= {sv[0], rd_data};
         stag0 <= mem_address;
         stag1 <= stag0;
      end
   end

   // Registered FIFO head plus pointer bookkeeping; a push into an empty FIFO
   // bypasses the storage and lands directly in the head.
   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_index <= '0;
         out_last  <= 1'b0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         store_cnt <= '0;
      end else begin
         if (store_we) wr_ptr <= inc_ptr(wr_ptr);
         if (store_re) rd_ptr <= inc_ptr(rd_ptr);
         store_cnt <= store_cnt + CW'(store_we) - CW'(store_re);
         if (head_free) begin
            if (store_re) begin
               {out_data, out_index, out_last} <= store[rd_ptr];
               out_valid <= 1'b1;
            end else if (push) begin
               {out_data, out_index, out_last} <= push_entry;
               out_valid <= 1'b1;
            end else begin
               out_valid <= 1'b0;
            end
         end
      end
   end

   // FIFO storage behind the head.
   always_ff @(posedge clock) begin
      if (store_we) store[wr_ptr] <= push_entry;
   end

   // Credit control must keep total occupancy within FIFO_DEPTH.
   assert property (@(posedge clock) disable iff (rst)
                    !(push && !pop && (total == CW'(FIFO_DEPTH))));

endmodule

// File: tb/tb_cell_pos_reader.sv
// Directed testbench for cell_pos_reader with a 2-cycle-latency memory model.
module tb_cell_pos_reader;

   localparam int MAXC = 512;

   logic        clock, rst, start;
   logic        busy, done, mem_rden, out_valid, out_ready, out_last;
   logic [7:0]  particle_count, mem_address, out_index;
   logic [95:0] mem_q, out_data;

   logic [95:0] mem [0:255];
   logic [95:0] q1;

   int checks = 0;
   int errors = 0;

   // per-run observation logs
   bit         v_log    [MAXC];
   int         idx_log  [MAXC];
   logic [95:0] dat_log [MAXC];
   bit         last_log [MAXC];
   bit         busy_log [MAXC];
   int         acc_idx[$];
   logic [95:0] acc_data[$];
   bit         acc_last[$];
   int done_cnt, done_cyc, first_v, data_reads, addr0_reads, max_rd, reads_by20;
   bit timed_out, aborted;
   logic [124:0] snap;

   cell_pos_reader dut (
      .clock(clock), .rst(rst), .start(start), .busy(busy), .done(done),
      .particle_count(particle_count), .mem_address(mem_address), .mem_rden(mem_rden),
      .mem_q(mem_q), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_index(out_index), .out_last(out_last)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [95:0] word(input int i);
      return {32'hC000_0000 + 32'(i), 32'hB000_0000 + 32'(i), 32'hA000_0000 + 32'(i)};
   endfunction

   // memory: read data appears two cycles after the read strobe
   always @(posedge clock) begin
      q1    <= mem_rden ? mem[mem_address] : 96'hDEAD_DEAD_DEAD_DEAD_DEAD_DEAD;
      mem_q <= q1;
   end

   // Drive one start pulse (cycle 0) and log every following cycle.
   task automatic run_cell(input logic [95:0] cnt_word, input int mode, input int abort_idx,
                           input int max_cyc);
      mem[0] = cnt_word;
      acc_idx.delete(); acc_data.delete(); acc_last.delete();
      for (int i = 0; i < MAXC; i++) begin
         v_log[i] = 0; idx_log[i] = 0; dat_log[i] = '0; last_log[i] = 0; busy_log[i] = 0;
      end
      done_cnt = 0; done_cyc = -1; first_v = -1; data_reads = 0; addr0_reads = 0;
      max_rd = 0; reads_by20 = 0; timed_out = 0; aborted = 0; snap = '1;
      @(negedge clock); start = 1'b1;
      @(posedge clock); #1; start = 1'b0;
      for (int n = 1; n < max_cyc; n++) begin
         case (mode)
            1:       out_ready = !(n >= 7 && n <= 20);
            2:       out_ready = (n % 2 == 1);
            default: out_ready = 1'b1;
         endcase
         v_log[n] = out_valid; idx_log[n] = int'(out_index); dat_log[n] = out_data;
         last_log[n] = out_last; busy_log[n] = busy;
         if (mem_rden) begin
            if (mem_address == 8'd0) addr0_reads++;
            else begin
               data_reads++;
               if (n <= 20) reads_by20++;
               if (int'(mem_address) > max_rd) max_rd = int'(mem_address);
            end
         end
         if (out_valid && first_v < 0) first_v = n;
         if (out_valid && out_ready) begin
            acc_idx.push_back(int'(out_index)); acc_data.push_back(out_data);
            acc_last.push_back(out_last);
         end
         if (done) begin done_cnt++; if (done_cyc < 0) done_cyc = n; end
         if (abort_idx != 0 && out_valid && int'(out_index) == abort_idx) begin
            #2 rst = 1'b1;
            #1 snap = {busy, done, particle_count, mem_address, mem_rden, out_valid,
                       out_data, out_index, out_last};
            aborted = 1;
            break;
         end
         if (done_cyc > 0 && n >= done_cyc + 3) break;
         @(posedge clock); #1;
      end
      if (done_cyc < 0 && !aborted) timed_out = 1;
      out_ready = 1'b1;
   endtask

   task automatic test_reset;
      checks++;
      if ({busy, done, mem_rden, out_valid, out_last} !== 5'b0) begin
         errors++; $display("FAIL reset_ctrl: got %b want 00000", {busy, done, mem_rden, out_valid, out_last});
      end
      checks++;
      if ({particle_count, mem_address, out_index} !== 24'h0) begin
         errors++; $display("FAIL reset_regs: got %h want 000000", {particle_count, mem_address, out_index});
      end
      checks++;
      if (out_data !== 96'h0) begin errors++; $display("FAIL reset_data: got %h want 0", out_data); end
      @(negedge clock); rst = 1'b0;
      repeat (2) @(negedge clock);
   endtask

   task automatic test_count3;
      run_cell({32'h1234_5678, 32'h0, 32'h0000_0F03}, 0, 0, 100);
      checks++; if (timed_out) begin errors++; $display("FAIL c3_timeout: got no done want done"); end
      checks++; if (first_v !== 7) begin errors++; $display("FAIL c3_first_valid: got %0d want 7", first_v); end
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (!v_log[7+k] || idx_log[7+k] !== k + 1 || dat_log[7+k] !== word(k + 1) || last_log[7+k] !== (k == 2)) begin
            errors++; $display("FAIL c3_word%0d: got v=%0d idx=%0d data=%h last=%0d want v=1 idx=%0d data=%h last=%0d",
                               k + 1, v_log[7+k], idx_log[7+k], dat_log[7+k], last_log[7+k], k + 1, word(k + 1), k == 2);
         end
      end
      checks++; if (v_log[10] !== 0) begin errors++; $display("FAIL c3_valid_after: got 1 want 0"); end
      checks++; if (done_cyc !== 10 || done_cnt !== 1) begin
         errors++; $display("FAIL c3_done: got cyc=%0d n=%0d want cyc=10 n=1", done_cyc, done_cnt); end
      checks++; if (!busy_log[1] || !busy_log[9] || busy_log[10]) begin
         errors++; $display("FAIL c3_busy: got b1=%0d b9=%0d b10=%0d want 1 1 0", busy_log[1], busy_log[9], busy_log[10]); end
      checks++; if (particle_count !== 8'd3) begin errors++; $display("FAIL c3_count: got %0d want 3", particle_count); end
      checks++; if (data_reads !== 3 || max_rd !== 3) begin
         errors++; $display("FAIL c3_reads: got n=%0d max=%0d want n=3 max=3", data_reads, max_rd); end
      checks++; if (mem_address !== 8'd3 || mem_rden !== 1'b0) begin
         errors++; $display("FAIL c3_addr_hold: got addr=%0d rden=%0d want 3 0", mem_address, mem_rden); end
   endtask

   task automatic test_zero;
      repeat (2) @(negedge clock);
      run_cell(96'h0, 0, 0, 60);
      checks++; if (timed_out || done_cyc !== 4 || done_cnt !== 1) begin
         errors++; $display("FAIL zero_done: got cyc=%0d n=%0d want cyc=4 n=1", done_cyc, done_cnt); end
      checks++; if (data_reads !== 0 || addr0_reads !== 1) begin
         errors++; $display("FAIL zero_reads: got data=%0d addr0=%0d want 0 1", data_reads, addr0_reads); end
      checks++; if (first_v !== -1) begin errors++; $display("FAIL zero_valid: got first=%0d want none", first_v); end
      checks++; if (particle_count !== 8'd0) begin errors++; $display("FAIL zero_count: got %0d want 0", particle_count); end
   endtask

   task automatic test_backpressure;
      int hold;
      repeat (2) @(negedge clock);
      run_cell(96'd10, 1, 0, 200);
      hold = 0;
      for (int n = 7; n <= 20; n++)
         if (v_log[n] && idx_log[n] == 1 && dat_log[n] == word(1)) hold++;
      checks++; if (hold !== 14) begin errors++; $display("FAIL bp_hold: got %0d want 14", hold); end
      checks++; if (reads_by20 !== 4) begin errors++; $display("FAIL bp_credit: got %0d want 4", reads_by20); end
      checks++; if (acc_idx.size() !== 10) begin errors++; $display("FAIL bp_size: got %0d want 10", acc_idx.size()); end
      for (int i = 0; i < acc_idx.size(); i++) begin
         checks++;
         if (acc_idx[i] !== i + 1 || acc_data[i] !== word(i + 1) || acc_last[i] !== (i == 9)) begin
            errors++; $display("FAIL bp_seq%0d: got idx=%0d last=%0d want idx=%0d last=%0d", i, acc_idx[i], acc_last[i], i + 1, i == 9);
         end
      end
      checks++; if (timed_out || done_cnt !== 1) begin errors++; $display("FAIL bp_done: got %0d want 1", done_cnt); end
   endtask

   task automatic test_toggle;
      repeat (2) @(negedge clock);
      run_cell(96'd10, 2, 0, 200);
      checks++; if (acc_idx.size() !== 10) begin errors++; $display("FAIL tg_size: got %0d want 10", acc_idx.size()); end
      for (int i = 0; i < acc_idx.size(); i++) begin
         checks++;
         if (acc_idx[i] !== i + 1 || acc_data[i] !== word(i + 1) || acc_last[i] !== (i == 9)) begin
            errors++; $display("FAIL tg_seq%0d: got idx=%0d last=%0d want idx=%0d last=%0d", i, acc_idx[i], acc_last[i], i + 1, i == 9);
         end
      end
      checks++; if (timed_out || done_cnt !== 1) begin errors++; $display("FAIL tg_done: got %0d want 1", done_cnt); end
   endtask

   task automatic test_clamp;
      int bad;
      repeat (2) @(negedge clock);
      run_cell(96'hFF, 0, 0, 400);
      checks++; if (particle_count !== 8'd219) begin errors++; $display("FAIL cl_count: got %0d want 219", particle_count); end
      checks++; if (max_rd !== 219 || data_reads !== 219) begin
         errors++; $display("FAIL cl_reads: got max=%0d n=%0d want 219 219", max_rd, data_reads); end
      checks++; if (acc_idx.size() !== 219) begin errors++; $display("FAIL cl_size: got %0d want 219", acc_idx.size()); end
      bad = 0;
      for (int i = 0; i < acc_idx.size(); i++)
         if (acc_idx[i] != i + 1 || acc_data[i] != word(i + 1) || acc_last[i] != (i == 218)) bad++;
      checks++; if (bad !== 0) begin errors++; $display("FAIL cl_seq: got %0d bad words want 0", bad); end
      checks++; if (timed_out || done_cnt !== 1) begin errors++; $display("FAIL cl_done: got %0d want 1", done_cnt); end
   endtask

   task automatic test_reset_midstream;
      int dn;
      repeat (2) @(negedge clock);
      run_cell(96'd10, 0, 5, 100);
      checks++; if (!aborted) begin errors++; $display("FAIL rs_reach: got no index 5 want index 5"); end
      checks++; if (snap !== '0) begin errors++; $display("FAIL rs_outputs: got %h want 0", snap); end
      dn = 0;
      repeat (3) begin @(posedge clock); #1; if (done) dn++; end
      @(negedge clock); rst = 1'b0;
      repeat (4) begin @(posedge clock); #1; if (done || busy) dn++; end
      checks++; if (dn !== 0) begin errors++; $display("FAIL rs_no_done: got %0d want 0", dn); end
      run_cell(96'd3, 0, 0, 100);
      checks++; if (first_v !== 7 || acc_idx.size() !== 3) begin
         errors++; $display("FAIL rs_restart: got first=%0d n=%0d want 7 3", first_v, acc_idx.size()); end
      checks++; if (acc_idx.size() > 0 && (acc_idx[0] !== 1 || acc_data[0] !== word(1))) begin
         errors++; $display("FAIL rs_first_idx: got %0d want 1", acc_idx[0]); end
      checks++; if (timed_out || done_cnt !== 1) begin errors++; $display("FAIL rs_done: got %0d want 1", done_cnt); end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = word(i);
      rst = 1'b1; start = 1'b0; out_ready = 1'b1;
      repeat (3) @(negedge clock);
      test_reset;
      test_count3;
      test_zero;
      test_backpressure;
      test_toggle;
      test_clamp;
      test_reset_midstream;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
